gen_rr_arbiter: RTL and testbench

- Registered, parametrised arbiter generalising the combinational first-one select (MS-first / LS-first).
- Adds a round-robin mode, grant locking, and encoded grant outputs.
- Sits between W requesters and one shared resource.
- Re-arbitrates every clock unless a lock holds the current grant.

---
 rtl/gen_rr_arbiter.sv | 88 ++++++++
 tb/tb_gen_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_rr_arbiter.sv
// Registered W-way arbiter: fixed MS-first, fixed LS-first or round-robin, with grant lock.
// Latency: one cycle from req/mode/lock to gnt, gnt_valid and gnt_idx.
// Backpressure: none; lock holds the current grant while its request stays asserted.
module gen_rr_arbiter #(
    parameter int W = 8,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  req,
    input  logic [1:0]    mode,
    input  logic          lock,
    output logic [W-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    generate
        if (W < 2 || W > 128) begin : g_bad_w
            $error("gen_rr_arbiter: W must be in 2..128");
        end
    endgenerate

    logic [IW-1:0] ptr;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] ptr_nxt;
    logic          sel_vld;
    logic          hold;

    assign hold = lock & gnt_valid & req[gnt_idx];

    // Later matches overwrite earlier ones, so each loop runs toward its highest-priority candidate.
    always_comb begin
        int scan;
        sel_idx = '0;
        sel_vld = 1'b0;
        scan    = 0;
        case (mode)
            2'b00: begin
                for (int i = 0; i < W; i++) begin
                    if (req[i]) begin
                        sel_idx = IW'(i);
                        sel_vld = 1'b1;
                    end
                end
            end
            2'b01: begin
                for (int i = W - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        sel_idx = IW'(i);
                        sel_vld = 1'b1;
                    end
                end
            end
            default: begin
                for (int k = W - 1; k >= 0; k--) begin
                    scan = int'(ptr) + k;
                    if (scan >= W) begin
                        scan = scan - W;
                    end
                    if (req[scan]) begin
                        sel_idx = IW'(scan);
                        sel_vld = 1'b1;
                    end
                end
            end
        endcase
    end

    assign ptr_nxt = (sel_idx == IW'(W - 1)) ? '0 : sel_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr       <= '0;
        end else if (!hold) begin
            gnt       <= sel_vld ? (W'(1) << sel_idx) : '0;
            gnt_valid <= sel_vld;
            gnt_idx   <= sel_idx;
            if (sel_vld) begin
                ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_gen_rr_arbiter.sv
// Bench for gen_rr_arbiter: W=4 and W=5 instances, directed scenarios plus random
// traffic checked against a scan-order reference model.
module tb_gen_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req4;
    logic [4:0] req5;
    logic [1:0] mode;
    logic       lock;
    logic [3:0] gnt4;
    logic       gv4;
    logic [1:0] idx4;
    logic [4:0] gnt5;
    logic       gv5;
    logic [2:0] idx5;

    int vectors = 0;
    int miss    = 0;

    // Reference state: granted index (-1 = none) and round-robin start position.
    int m4_g, m4_p, m5_g, m5_p;

    gen_rr_arbiter #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .mode(mode), .lock(lock),
        .gnt(gnt4), .gnt_valid(gv4), .gnt_idx(idx4)
    );

    gen_rr_arbiter #(.W(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode), .lock(lock),
        .gnt(gnt5), .gnt_valid(gv5), .gnt_idx(idx5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input int w, input logic [7:0] rq, input logic [1:0] md,
                                  input logic lk, inout int g, inout int p);
        int n;
        if (lk && g >= 0 && rq[g]) return;
        g = -1;
        if (rq == 8'd0) return;
        for (int k = 0; k < w; k++) begin
            case (md)
                2'd0:    n = w - 1 - k;
                2'd1:    n = k;
                default: n = (p + k) % w;
            endcase
            if (g < 0 && rq[n]) g = n;
        end
        p = (g + 1) % w;
    endfunction

    function automatic logic [7:0] onehot(input int g);
        logic [7:0] one;
        one = 8'd1;
        return (g < 0) ? 8'd0 : (one << g);
    endfunction

    function automatic int idx_of(input int g);
        return (g < 0) ? 0 : g;
    endfunction

    task automatic model_reset();
        m4_g = -1; m4_p = 0;
        m5_g = -1; m5_p = 0;
    endtask

    // Inputs change on the falling edge; the model advances on the rising edge.
    task automatic tick();
        @(posedge clk);
        model(4, {4'd0, req4}, mode, lock, m4_g, m4_p);
        model(5, {3'd0, req5}, mode, lock, m5_g, m5_p);
        @(negedge clk);
    endtask

    task automatic test_reset();
        req4 = '0; req5 = '0; mode = 2'b00; lock = 1'b0; rst_n = 1'b0;
        model_reset();
        #3;
        vectors++;
        if ({gnt4, gv4, idx4} !== 7'd0 || {gnt5, gv5, idx5} !== 9'd0) begin
            miss++;
            $display("FAIL reset_state got %b/%b want zeros", {gnt4, gv4, idx4}, {gnt5, gv5, idx5});
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode = 2'b01; req4 = 4'b0100;
        tick();
        vectors++;
        if ({gnt4, gv4, idx4} !== {4'b0100, 1'b1, 2'd2}) begin
            miss++;
            $display("FAIL pre_reset_grant got %b want %b", {gnt4, gv4, idx4}, {4'b0100, 1'b1, 2'd2});
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({gnt4, gv4, idx4} !== 7'd0) begin
            miss++;
            $display("FAIL async_reset got %b want 0000000", {gnt4, gv4, idx4});
        end
        @(negedge clk);
        rst_n = 1'b1; req4 = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if ({gnt4, gv4, idx4} !== 7'd0) begin
                miss++;
                $display("FAIL idle_after_reset got %b want 0000000", {gnt4, gv4, idx4});
            end
        end
    endtask

    task automatic test_fixed();
        req4 = 4'b1011; mode = 2'b00; lock = 1'b0;
        #1;
        vectors++;
        if (gnt4 !== 4'b0000) begin
            miss++;
            $display("FAIL ms_latency got %b want 0000", gnt4);
        end
        tick();
        vectors++;
        if ({gnt4, gv4, idx4} !== {4'b1000, 1'b1, 2'd3}) begin
            miss++;
            $display("FAIL ms_first got %b want %b", {gnt4, gv4, idx4}, {4'b1000, 1'b1, 2'd3});
        end
        mode = 2'b01;
        #1;
        vectors++;
        if (gnt4 !== 4'b1000) begin
            miss++;
            $display("FAIL ls_latency got %b want 1000", gnt4);
        end
        tick();
        vectors++;
        if ({gnt4, gv4, idx4} !== {4'b0001, 1'b1, 2'd0}) begin
            miss++;
            $display("FAIL ls_first got %b want %b", {gnt4, gv4, idx4}, {4'b0001, 1'b1, 2'd0});
        end
    endtask

    // Runs straight after test_fixed, whose last grant (index 0) left the pointer at 1.
    task automatic test_rr_skip();
        mode = 2'b10; req4 = 4'b0001;
        tick();
        vectors++;
        if ({gnt4, idx4} !== {4'b0001, 2'd0}) begin
            miss++;
            $display("FAIL rr_wrap got %b want %b", {gnt4, idx4}, {4'b0001, 2'd0});
        end
        req4 = 4'b1001;
        tick();
        vectors++;
        if ({gnt4, idx4} !== {4'b1000, 2'd3}) begin
            miss++;
            $display("FAIL rr_skip got %b want %b", {gnt4, idx4}, {4'b1000, 2'd3});
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0; req4 = '0; req5 = '0; lock = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rr_rotation();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_pulse();
        mode = 2'b10; req4 = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (gnt4 !== seq[c] || gv4 !== 1'b1) begin
                miss++;
                $display("FAIL rr_rotation[%0d] got %b want %b", c, gnt4, seq[c]);
            end
        end
    endtask

    task automatic test_lock_hold();
        reset_pulse();
        mode = 2'b10; req4 = 4'b1111;
        tick();
        lock = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if ({gnt4, idx4} !== {4'b0001, 2'd0}) begin
                miss++;
                $display("FAIL lock_hold[%0d] got %b want 000100", c, {gnt4, idx4});
            end
        end
        req4 = 4'b1110;
        tick();
        vectors++;
        if (gnt4 !== 4'b0010) begin
            miss++;
            $display("FAIL lock_release got %b want 0010", gnt4);
        end
        lock = 1'b0; req4 = 4'b1111;
        tick();
        vectors++;
        if (gnt4 !== 4'b0100) begin
            miss++;
            $display("FAIL lock_resume got %b want 0100", gnt4);
        end
    endtask

    task automatic test_npow2();
        reset_pulse();
        mode = 2'b10; req5 = 5'b10001;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if ((c % 2 == 0 && {gnt5, idx5} !== {5'b00001, 3'd0}) ||
                (c % 2 == 1 && {gnt5, idx5} !== {5'b10000, 3'd4})) begin
                miss++;
                $display("FAIL npow2[%0d] got gnt=%b idx=%0d", c, gnt5, idx5);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req4 = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            req5 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mode = 2'($urandom);
            lock = 1'($urandom);
            tick();
            vectors++;
            if (gnt4 !== onehot(m4_g)[3:0] || gv4 !== (m4_g >= 0) || idx4 !== 2'(idx_of(m4_g))) begin
                miss++;
                $display("FAIL random_w4[%0d] got gnt=%b v=%b idx=%0d want gnt=%b idx=%0d",
                         c, gnt4, gv4, idx4, onehot(m4_g)[3:0], idx_of(m4_g));
            end
            vectors++;
            if (gnt5 !== onehot(m5_g)[4:0] || gv5 !== (m5_g >= 0) || idx5 !== 3'(idx_of(m5_g))) begin
                miss++;
                $display("FAIL random_w5[%0d] got gnt=%b v=%b idx=%0d want gnt=%b idx=%0d",
                         c, gnt5, gv5, idx5, onehot(m5_g)[4:0], idx_of(m5_g));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_skip();
        test_rr_rotation();
        test_lock_hold();
        test_npow2();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
